// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared definitions for the waveform generator front panel.
// Mode encodings, per-parameter limits and reset values, phase modulus,
// and the cursor-to-step lookup used by the parameter editor.
package wavegen_pkg;

  typedef enum logic [3:0] {
    MODE_FREQ  = 4'd0,
    MODE_PHASE = 4'd1,
    MODE_DUTY  = 4'd2,
    MODE_RANGE = 4'd3,
    MODE_SPEED = 4'd4
  } mode_t;

  // Width of the signed edit arithmetic; 999 + 100 must not overflow.
  localparam int unsigned CALC_W = 12;

  localparam logic signed [CALC_W-1:0] FREQ_MIN  = 12'sd1;
  localparam logic signed [CALC_W-1:0] FREQ_MAX  = 12'sd999;
  localparam logic signed [CALC_W-1:0] FREQ_RST  = 12'sd1;
  localparam logic signed [CALC_W-1:0] PHASE_RST = 12'sd0;
  localparam logic signed [CALC_W-1:0] DUTY_MIN  = 12'sd1;
  localparam logic signed [CALC_W-1:0] DUTY_MAX  = 12'sd99;
  localparam logic signed [CALC_W-1:0] DUTY_RST  = 12'sd50;
  localparam logic signed [CALC_W-1:0] RANGE_MIN = 12'sd0;
  localparam logic signed [CALC_W-1:0] RANGE_MAX = 12'sd999;
  localparam logic signed [CALC_W-1:0] RANGE_RST = 12'sd100;
  localparam logic signed [CALC_W-1:0] SPEED_MIN = 12'sd1;
  localparam logic signed [CALC_W-1:0] SPEED_MAX = 12'sd99;
  localparam logic signed [CALC_W-1:0] SPEED_RST = 12'sd10;

  localparam logic signed [CALC_W-1:0] PHASE_MODULUS = 12'sd360;

  // Digit weight for the cursor position (0 = units).
  function automatic logic signed [CALC_W-1:0] step_of(input logic [2:0] cursor);
    case (cursor)
      3'd0:    return 12'sd1;
      3'd1:    return 12'sd10;
      default: return 12'sd100;
    endcase
  endfunction

  // Highest editable digit: two-digit parameters stop at the tens digit.
  function automatic logic [2:0] cmax_of(input mode_t m);
    case (m)
      MODE_DUTY, MODE_SPEED: return 3'd1;
      default:               return 3'd2;
    endcase
  endfunction

  function automatic logic signed [CALC_W-1:0] clamp(
    input logic signed [CALC_W-1:0] v,
    input logic signed [CALC_W-1:0] lo,
    input logic signed [CALC_W-1:0] hi
  );
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on each accepted 0->1 transition. Release emits no pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Synchronize, count while the sample disagrees with the accepted state,
  // accept after the sample has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync[1];
        pulse <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_editor.sv
// param_editor: debounces the five push-buttons and edits the waveform
// parameters digit by digit. Optional auto-repeat of up/down while held is
// enabled by defining PARAM_EDITOR_AUTOREPEAT_EN.
module param_editor
  import wavegen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [19:0] value,
  output logic [3:0]  mode,
  output logic [2:0]  cursor,
  output logic [9:0]  freq_khz,
  output logic [8:0]  phase_deg,
  output logic [6:0]  duty_pct,
  output logic [9:0]  sweep_range,
  output logic [6:0]  sweep_speed
);

  logic up_p, dn_p, l_p, r_p, c_p;
  logic up_lvl, dn_lvl, l_lvl, r_lvl, c_lvl;
  logic rep_up, rep_dn, up_ev, dn_ev;
  logic act_center, act_left, act_right, act_up, act_down;
  mode_t mode_q;
  logic [2:0] cursor_q;
  logic signed [CALC_W-1:0] cur_val, step, sum, new_val;
  logic [19:0] act_val;
  logic unused_lvl;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .level(up_lvl), .pulse(up_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .level(dn_lvl), .pulse(dn_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .btn(btn_left), .level(l_lvl), .pulse(l_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .btn(btn_right), .level(r_lvl), .pulse(r_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_center (
    .clk(clk), .rst_n(rst_n), .btn(btn_center), .level(c_lvl), .pulse(c_p));

  // One action per clock: center > left > right > up > down.
  assign up_ev      = up_p | rep_up;
  assign dn_ev      = dn_p | rep_dn;
  assign act_center = c_p;
  assign act_left   = l_p & ~c_p;
  assign act_right  = r_p & ~c_p & ~l_p;
  assign act_up     = up_ev & ~c_p & ~l_p & ~r_p;
  assign act_down   = dn_ev & ~c_p & ~l_p & ~r_p & ~up_ev;

`ifdef PARAM_EDITOR_AUTOREPEAT_EN
  logic [31:0] rep_cnt;
  logic rep_armed, rep_restart, rep_fire;

  assign unused_lvl  = ^{l_lvl, r_lvl, c_lvl};
  assign rep_restart = up_p | dn_p | act_center | act_left | act_right | ~(up_lvl | dn_lvl);
  assign rep_fire    = ~rep_restart &&
                       (rep_cnt == (rep_armed ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1)));
  assign rep_up      = rep_fire & up_lvl;
  assign rep_dn      = rep_fire & dn_lvl;

  // Repeat timer: first delay after a press, then a fixed period until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_restart) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 32'd1;
    end
  end
`else
  localparam int unsigned UNUSED_REPEAT = REPEAT_DELAY + REPEAT_PERIOD;
  assign unused_lvl = ^{up_lvl, dn_lvl, l_lvl, r_lvl, c_lvl};
  assign rep_up     = 1'b0;
  assign rep_dn     = 1'b0;
`endif

  // Step the active parameter, clamping or wrapping as that parameter requires.
  always_comb begin
    cur_val = '0;
    case (mode_q)
      MODE_FREQ:  cur_val = {2'b0, freq_khz};
      MODE_PHASE: cur_val = {3'b0, phase_deg};
      MODE_DUTY:  cur_val = {5'b0, duty_pct};
      MODE_RANGE: cur_val = {2'b0, sweep_range};
      MODE_SPEED: cur_val = {5'b0, sweep_speed};
      default:    cur_val = '0;
    endcase
    step    = step_of(cursor_q);
    sum     = act_up ? (cur_val + step) : (cur_val - step);
    new_val = sum;
    case (mode_q)
      MODE_FREQ:  new_val = clamp(sum, FREQ_MIN, FREQ_MAX);
      MODE_PHASE: begin
        if (sum >= PHASE_MODULUS)  new_val = sum - PHASE_MODULUS;
        else if (sum < 12'sd0)     new_val = sum + PHASE_MODULUS;
        else                       new_val = sum;
      end
      MODE_DUTY:  new_val = clamp(sum, DUTY_MIN, DUTY_MAX);
      MODE_RANGE: new_val = clamp(sum, RANGE_MIN, RANGE_MAX);
      MODE_SPEED: new_val = clamp(sum, SPEED_MIN, SPEED_MAX);
      default:    new_val = sum;
    endcase
  end

  // Mode, cursor and parameter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_FREQ;
      cursor_q    <= '0;
      freq_khz    <= FREQ_RST[9:0];
      phase_deg   <= PHASE_RST[8:0];
      duty_pct    <= DUTY_RST[6:0];
      sweep_range <= RANGE_RST[9:0];
      sweep_speed <= SPEED_RST[6:0];
    end else if (act_center) begin
      cursor_q <= '0;
      case (mode_q)
        MODE_FREQ:  mode_q <= MODE_PHASE;
        MODE_PHASE: mode_q <= MODE_DUTY;
        MODE_DUTY:  mode_q <= MODE_RANGE;
        MODE_RANGE: mode_q <= MODE_SPEED;
        default:    mode_q <= MODE_FREQ;
      endcase
    end else if (act_left) begin
      if (cursor_q < cmax_of(mode_q)) cursor_q <= cursor_q + 3'd1;
    end else if (act_right) begin
      if (cursor_q != 3'd0) cursor_q <= cursor_q - 3'd1;
    end else if (act_up || act_down) begin
      case (mode_q)
        MODE_FREQ:  freq_khz    <= new_val[9:0];
        MODE_PHASE: phase_deg   <= new_val[8:0];
        MODE_DUTY:  duty_pct    <= new_val[6:0];
        MODE_RANGE: sweep_range <= new_val[9:0];
        MODE_SPEED: sweep_speed <= new_val[6:0];
        default:    ;
      endcase
    end
  end

  // Select the active parameter for the display.
  always_comb begin
    act_val = '0;
    case (mode_q)
      MODE_FREQ:  act_val = {10'b0, freq_khz};
      MODE_PHASE: act_val = {11'b0, phase_deg};
      MODE_DUTY:  act_val = {13'b0, duty_pct};
      MODE_RANGE: act_val = {10'b0, sweep_range};
      MODE_SPEED: act_val = {13'b0, sweep_speed};
      default:    act_val = '0;
    endcase
  end

  // Display-side outputs, one clock behind the internal state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= 4'(MODE_FREQ);
      cursor <= '0;
      value  <= 20'(FREQ_RST);
    end else begin
      mode   <= mode_q;
      cursor <= cursor_q;
      value  <= act_val;
    end
  end

endmodule

// File: tb/tb_param_editor.sv
// tb_param_editor: randomized self-checking bench for param_editor against
// a behavioural parameter-editing model.
module tb_param_editor;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [19:0] value;
  logic [3:0]  mode;
  logic [2:0]  cursor;
  logic [9:0]  freq_khz;
  logic [8:0]  phase_deg;
  logic [6:0]  duty_pct;
  logic [9:0]  sweep_range;
  logic [6:0]  sweep_speed;

  param_editor #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .value(value), .mode(mode), .cursor(cursor),
    .freq_khz(freq_khz), .phase_deg(phase_deg), .duty_pct(duty_pct),
    .sweep_range(sweep_range), .sweep_speed(sweep_speed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: 0 center, 1 left, 2 right, 3 up, 4 down.
  int m_mode, m_cur;
  int m_p[5];
  int P_MIN[5] = '{1, 0, 1, 0, 1};
  int P_MAX[5] = '{999, 359, 99, 999, 99};
  int P_RST[5] = '{1, 0, 50, 100, 10};
  int P_DIG[5] = '{3, 3, 2, 3, 2};

  function automatic void m_reset();
    m_mode = 0;
    m_cur  = 0;
    for (int i = 0; i < 5; i++) m_p[i] = P_RST[i];
  endfunction

  function automatic void m_press(input int b);
    int v;
    int step;
    step = (m_cur == 0) ? 1 : (m_cur == 1) ? 10 : 100;
    case (b)
      0: begin m_mode = (m_mode + 1) % 5; m_cur = 0; end
      1: if (m_cur < P_DIG[m_mode] - 1) m_cur++;
      2: if (m_cur > 0) m_cur--;
      default: begin
        v = (b == 3) ? m_p[m_mode] + step : m_p[m_mode] - step;
        if (m_mode == 1) v = ((v % 360) + 360) % 360;
        else if (v < P_MIN[m_mode]) v = P_MIN[m_mode];
        else if (v > P_MAX[m_mode]) v = P_MAX[m_mode];
        m_p[m_mode] = v;
      end
    endcase
  endfunction

  function automatic logic [69:0] exp_vec();
    return {4'(m_mode), 3'(m_cur), 20'(m_p[m_mode]), 10'(m_p[0]), 9'(m_p[1]),
            7'(m_p[2]), 10'(m_p[3]), 7'(m_p[4])};
  endfunction

  logic [69:0] act_vec;
  assign act_vec = {mode, cursor, value, freq_khz, phase_deg, duty_pct, sweep_range, sweep_speed};

  task automatic set_btn(input int b, input logic lvl);
    case (b)
      0: btn_center = lvl;
      1: btn_left   = lvl;
      2: btn_right  = lvl;
      3: btn_up     = lvl;
      default: btn_down = lvl;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (12) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (12) @(negedge clk);
    m_press(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right, btn_center} = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    m_reset();
  endtask

  task automatic test_reset();
    {btn_up, btn_down, btn_left, btn_right, btn_center} = '0;
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_asserted: got %h expected %h", act_vec, exp_vec());
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_released: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_bounce();
    int n;
    do_reset();
    btn_up = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      n = $urandom_range(1, 2);
      repeat (n) @(negedge clk);
    end
    n_checks++;
    if (freq_khz !== 10'd1) begin
      n_fail++;
      $display("FAIL bounce_rejected: freq got %0d expected 1", freq_khz);
    end
    btn_up = 1'b1;
    n = 0;
    while (freq_khz == 10'd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (freq_khz !== 10'd2) begin
      n_fail++;
      $display("FAIL bounce_accept: freq got %0d expected 2", freq_khz);
    end
    n_checks++;
    if (value !== 20'd1) begin
      n_fail++;
      $display("FAIL value_latency: value got %0d expected 1 (one clock behind)", value);
    end
    @(negedge clk);
    n_checks++;
    if (value !== 20'd2) begin
      n_fail++;
      $display("FAIL value_follow: value got %0d expected 2", value);
    end
    btn_up = 1'b0;
    repeat (15) @(negedge clk);
    m_press(3);
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL bounce_single: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_cursor_clamp();
    int seq[13] = '{1, 1, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 1};
    do_reset();
    foreach (seq[i]) begin
      press(seq[i]);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL cursor_clamp[%0d]: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_phase_wrap();
    int seq[8] = '{0, 1, 1, 3, 3, 3, 3, 4};
    do_reset();
    foreach (seq[i]) begin
      press(seq[i]);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL phase_wrap[%0d]: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_mode_cycle();
    int seq[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3};
    do_reset();
    foreach (seq[i]) begin
      press(seq[i]);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL mode_cycle[%0d]: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_center = 1'b1;
    btn_up     = 1'b1;
    repeat (12) @(negedge clk);
    btn_center = 1'b0;
    btn_up     = 1'b0;
    repeat (12) @(negedge clk);
    m_press(0);
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL center_over_up: got %h expected %h", act_vec, exp_vec());
    end
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", act_vec, exp_vec());
    end
    btn_up = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL no_pulse_after_reset: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_autorepeat();
    int n;
    do_reset();
    btn_up = 1'b1;
    n = 0;
    while (freq_khz == 10'd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (freq_khz !== 10'd2) begin
      n_fail++;
      $display("FAIL hold_first_step: freq got %0d expected 2", freq_khz);
    end
    repeat (36) @(negedge clk);
    btn_up = 1'b0;
    repeat (15) @(negedge clk);
`ifdef PARAM_EDITOR_AUTOREPEAT_EN
    m_p[0] = 7;
`else
    m_p[0] = 2;
`endif
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL hold_total: got %h expected %h (freq %0d vs %0d)",
               act_vec, exp_vec(), freq_khz, m_p[0]);
    end
  endtask

  task automatic test_random();
    int b;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      b = $urandom_range(0, 4);
      if ($urandom_range(0, 2) != 0) b = 3 + $urandom_range(0, 1);
      press(b);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] btn %0d: got %h expected %h", i, b, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_cursor_clamp();
    test_phase_wrap();
    test_mode_cycle();
    test_simultaneous();
    test_autorepeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
